// File: rtl/ffinv_iter.sv
// GF(2^m) multiplicative inverse a^(2^m-2), one square plus one multiply per clock.
// Latency: out_valid at T+m for legal grades (T+1 for m==1 or an illegal grade).
// Backpressure: in_ready only while idle; requests seen while busy are ignored.

module ffsqr #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH):0] grade,
  input  logic [DATA_WIDTH:0]         poly,
  input  logic [DATA_WIDTH-1:0]       a,
  output logic [DATA_WIDTH-1:0]       sq
);
  logic [2*DATA_WIDTH-1:0] t;

  always_comb begin
    t = '0;
    for (int i = 0; i < DATA_WIDTH; i++) t[2*i] = a[i];
    // Fold every set bit at or above x^m back down with the reduction polynomial
    for (int i = 2*DATA_WIDTH-2; i > 0; i--) begin
      if (i >= int'(grade) && t[i])
        t = t ^ ({{(DATA_WIDTH-1){1'b0}}, poly} << (i - int'(grade)));
    end
    sq = t[DATA_WIDTH-1:0];
  end
endmodule

module ffmul #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [$clog2(DATA_WIDTH):0] grade,
  input  logic [DATA_WIDTH:0]         poly,
  input  logic [DATA_WIDTH-1:0]       a,
  input  logic [DATA_WIDTH-1:0]       b,
  output logic [DATA_WIDTH-1:0]       p
);
  logic [DATA_WIDTH:0] r;

  // MSB-first shift-and-add with reduction after each shift
  always_comb begin
    r = '0;
    for (int i = DATA_WIDTH-1; i >= 0; i--) begin
      r = {r[DATA_WIDTH-1:0], 1'b0};
      if (r[grade]) r = r ^ poly;
      if (b[i]) r = r ^ {1'b0, a};
    end
    p = r[DATA_WIDTH-1:0];
  end
endmodule

module ffinv_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [$clog2(DATA_WIDTH):0]   polyn_grade,
  input  logic [DATA_WIDTH:0]           polyn_red_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_WIDTH-1:0]         in_a,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out,
  output logic                          busy,
  output logic                          err
);
  localparam int GW = $clog2(DATA_WIDTH) + 1;
  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] sq, acc, sq_next, mul_out, a_masked;
  logic [GW-1:0]         grade_q, count;
  logic [DATA_WIDTH:0]   poly_q;
  logic                  grade_ok;

  assign a_masked = in_a & ~({DATA_WIDTH{1'b1}} << polyn_grade);
  assign grade_ok = (polyn_grade != '0) && (polyn_grade <= GW'(DATA_WIDTH));
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Field ops run on the captured grade/polynomial so the CSR source may change mid-op
  ffsqr #(.DATA_WIDTH(DATA_WIDTH)) u_sqr (
    .grade (grade_q),
    .poly  (poly_q),
    .a     (sq),
    .sq    (sq_next)
  );

  ffmul #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
    .grade (grade_q),
    .poly  (poly_q),
    .a     (acc),
    .b     (sq_next),
    .p     (mul_out)
  );

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      sq        <= '0;
      acc       <= '0;
      count     <= '0;
      grade_q   <= '0;
      poly_q    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            grade_q <= polyn_grade;
            poly_q  <= polyn_red_in;
            sq      <= a_masked;
            acc     <= ONE;
            if (!grade_ok) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out       <= '0;
              err       <= 1'b1;
            end else if (polyn_grade == GW'(1)) begin
              state     <= DONE;
              out_valid <= 1'b1;
              out       <= a_masked;
              err       <= 1'b0;
            end else begin
              count <= polyn_grade - GW'(1);
              state <= CALC;
            end
          end
        end
        CALC: begin
          sq    <= sq_next;
          acc   <= mul_out;
          count <= count - GW'(1);
          if (count == GW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out       <= mul_out;
            err       <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ffinv_iter.sv
// Bench for ffinv_iter: vector table, exhaustive GF(2^8), random GF(2^32), busy and reset corners.
module tb_ffinv_iter;
  logic        clk = 1'b0;
  logic        rst_l = 1'b1;
  logic [5:0]  polyn_grade = '0;
  logic [32:0] polyn_red_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic        out_valid;
  logic [31:0] out;
  logic        busy;
  logic        err;

  ffinv_iter #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .polyn_grade  (polyn_grade),
    .polyn_red_in (polyn_red_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .out_valid    (out_valid),
    .out          (out),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  g;
    logic [32:0] p;
    logic [31:0] a;
    logic [31:0] exp;
    logic        eerr;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    logic        eerr;
    int          lat;
    int          acc_cyc;
    logic [31:0] am;
    int          m;
    logic [32:0] poly;
    logic        mulchk;
  } sb_t;

  sb_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Carry-less product followed by long division by the field polynomial
  function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                         input int m, input logic [32:0] poly);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 32; i++) if (b[i]) p = p ^ ({32'b0, a} << i);
    for (int i = 63; i >= m; i--) if (p[i]) p = p ^ ({31'b0, poly} << (i - m));
    return p[31:0];
  endfunction

  function automatic logic [31:0] gf_inv_pow(input logic [31:0] a, input int m, input logic [32:0] poly);
    logic [31:0] r, base;
    longint unsigned e;
    r = 32'h1;
    base = a;
    e = (64'd1 << m) - 64'd2;
    while (e != 0) begin
      if (e[0]) r = gf_mul(r, base, m, poly);
      base = gf_mul(base, base, m, poly);
      e = e >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] gf_inv_search(input logic [31:0] a, input int m, input logic [32:0] poly);
    logic [31:0] b;
    for (int i = 1; i < (1 << m); i++) begin
      b = i;
      if (gf_mul(a, b, m, poly) == 32'h1) return b;
    end
    return 32'h0;
  endfunction

  always @(negedge clk) begin
    if (rst_l && out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out_valid: got out=0x%0h with no pending request", out);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("out", out, e.exp);
        chk("err", err, e.eerr);
        chk("latency", cyc, e.acc_cyc + e.lat);
        if (e.mulchk) chk("a_times_inv", gf_mul(out, e.am, e.m, e.poly), 1);
      end
    end
  end

  task automatic issue(input logic [5:0] g, input logic [32:0] p, input logic [31:0] a,
                       input logic [31:0] exp, input logic eerr);
    sb_t e;
    int n;
    @(negedge clk);
    polyn_grade = g;
    polyn_red_in = p;
    in_a = a;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    e.exp = exp;
    e.eerr = eerr;
    e.lat = (eerr || g == 6'd1) ? 1 : int'(g);
    e.acc_cyc = cyc;
    e.am = a & ~(32'hFFFF_FFFF << g);
    e.m = int'(g);
    e.poly = p;
    e.mulchk = !eerr && (e.am != 0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    polyn_grade = 6'($urandom);
    polyn_red_in = {1'($urandom), $urandom};
    in_a = $urandom;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[10];
    logic [31:0] ra;
    vecs[0] = '{6'd4,  33'h13,  32'h2,   32'h9,  1'b0};
    vecs[1] = '{6'd4,  33'h13,  32'h1,   32'h1,  1'b0};
    vecs[2] = '{6'd8,  33'h11B, 32'h53,  32'hCA, 1'b0};
    vecs[3] = '{6'd8,  33'h11B, 32'h00,  32'h00, 1'b0};
    vecs[4] = '{6'd8,  33'h11B, 32'h153, 32'hCA, 1'b0};
    vecs[5] = '{6'd0,  33'h11B, 32'h53,  32'h00, 1'b1};
    vecs[6] = '{6'd33, 33'h11B, 32'h53,  32'h00, 1'b1};
    vecs[7] = '{6'd1,  33'h3,   32'h1,   32'h1,  1'b0};
    vecs[8] = '{6'd1,  33'h3,   32'h3,   32'h1,  1'b0};
    vecs[9] = '{6'd4,  33'h13,  32'hF2,  32'h9,  1'b0};

    #2 rst_l = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    repeat (2) @(negedge clk);
    rst_l = 1'b1;

    for (int i = 0; i < 10; i++)
      issue(vecs[i].g, vecs[i].p, vecs[i].a, vecs[i].exp, vecs[i].eerr);
    drain(100);

    // Busy window: in_ready low T+1..T+8, stray request ignored, result then held
    issue(6'd8, 33'h11B, 32'h53, 32'hCA, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("in_ready_busy", in_ready, 0);
      chk("busy_high", busy, 1);
      if (k == 3) begin
        in_valid = 1'b1;
        in_a = 32'h2;
        polyn_grade = 6'd8;
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("in_ready_after", in_ready, 1);
    chk("busy_after", busy, 0);
    chk("out_hold", out, 32'hCA);
    chk("out_valid_single", out_valid, 0);
    chk("pending_after_busy", sb.size(), 0);

    for (int a = 1; a < 256; a++) begin
      ra = a;
      issue(6'd8, 33'h11B, ra, gf_inv_search(ra, 8, 33'h11B), 1'b0);
    end
    drain(100);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      issue(6'd32, 33'h1_0000_008D, ra, gf_inv_pow(ra, 32, 33'h1_0000_008D), 1'b0);
    end
    drain(200);

    // Abort an m=8 op at T+3 with reset
    issue(6'd8, 33'h11B, 32'h53, 32'hCA, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_l = 1'b0;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_out", out, 0);
    chk("abort_err", err, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_l = 1'b1;
    repeat (12) @(negedge clk);
    issue(6'd4, 33'h13, 32'h2, 32'h9, 1'b0);
    drain(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
